// File: rtl/mpt_walk_stage.sv
// MPT walker stage: forwards PLB-hit transactions and performs a multi-level MPT table walk for misses.
// Optional saturating walk/fault counters are enabled by defining MPT_WALK_PERF_COUNTERS_EN.

package mpt_pkg;

  localparam int unsigned MPT_PPN_WIDTH = 44;
  localparam int unsigned MPT_SPA_WIDTH = 48;
  localparam int unsigned MPT_RPA_WIDTH = 64;

  typedef enum logic {
    MPT_WALKING_SKIP = 1'b0,
    MPT_WALKING_DO   = 1'b1
  } mpt_walking_e;

  typedef struct packed {
    logic [MPT_PPN_WIDTH-1:0] ppn;
  } mmpt_t;

  typedef struct packed {
    mpt_walking_e             walking;
    logic [1:0]               access_type;
    mmpt_t                    mmpt;
    logic [MPT_SPA_WIDTH-1:0] spa;
    logic [MPT_RPA_WIDTH-1:0] rpa;
  } mptw_transaction_t;

  localparam int unsigned MPTW_TRANSACTION_WIDTH = $bits(mptw_transaction_t);

endpackage

module mpt_walk_stage
  import mpt_pkg::*;
#(
  parameter int unsigned PIPELINE_SLAVE_DATA_WIDTH  = 32,
  parameter int unsigned PIPELINE_MASTER_DATA_WIDTH = 32,
  parameter int unsigned MEMORY_DATA_WIDTH          = 64,
  parameter int unsigned MEMORY_ADDR_WIDTH          = 64,
  parameter int unsigned WALK_LEVELS                = 3,
  parameter int unsigned LEVEL_IDX_WIDTH            = 9,
  parameter int unsigned PAGE_OFFSET_WIDTH          = 12
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  stage_slave_valid,
  output logic                                  stage_slave_ready,
  input  logic [PIPELINE_SLAVE_DATA_WIDTH-1:0]  stage_slave_data,
  output logic                                  stage_master_valid,
  input  logic                                  stage_master_ready,
  output logic [PIPELINE_MASTER_DATA_WIDTH-1:0] stage_master_data,
  output logic                                  walk_mem_req,
  input  logic                                  walk_mem_gnt,
  input  logic                                  walk_mem_valid,
  output logic [MEMORY_ADDR_WIDTH-1:0]          walk_mem_addr,
  input  logic [MEMORY_DATA_WIDTH-1:0]          walk_mem_rdata,
  output logic [MEMORY_DATA_WIDTH-1:0]          walk_mem_wdata,
  output logic                                  walk_mem_we,
  output logic [MEMORY_DATA_WIDTH/8-1:0]        walk_mem_be,
  input  logic                                  walk_mem_error
`ifdef MPT_WALK_PERF_COUNTERS_EN
  ,
  output logic [31:0]                           walk_count_o,
  output logic [31:0]                           fault_count_o
`endif
);

  localparam int unsigned TXN_W     = MPTW_TRANSACTION_WIDTH;
  localparam logic [1:0]  TOP_LEVEL = 2'(WALK_LEVELS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_e;

  state_e                       state_q;
  logic                         slave_ready_q;
  logic                         master_valid_q;
  logic                         mem_req_q;
  logic [MEMORY_ADDR_WIDTH-1:0] mem_addr_q;
  logic [1:0]                   level_q;
  mptw_transaction_t            txn_q;

  mptw_transaction_t            slv_txn_s;
  logic                         entry_v_s;
  logic                         entry_leaf_s;
  logic                         entry_fault_s;
  logic [MPT_PPN_WIDTH-1:0]     entry_ppn_s;
  logic [1:0]                   next_level_s;

  // Table entry address: base of the current table plus the 8-byte slot selected by this level's SPA index.
  function automatic logic [MEMORY_ADDR_WIDTH-1:0] entry_addr_f(
    input logic [MPT_PPN_WIDTH-1:0] ppn,
    input logic [1:0]               lvl,
    input logic [MPT_SPA_WIDTH-1:0] spa
  );
    logic [LEVEL_IDX_WIDTH-1:0] idx;
    idx = LEVEL_IDX_WIDTH'(spa >> (PAGE_OFFSET_WIDTH + LEVEL_IDX_WIDTH * 32'(lvl)));
    entry_addr_f = (MEMORY_ADDR_WIDTH'(ppn) << PAGE_OFFSET_WIDTH)
                 + (MEMORY_ADDR_WIDTH'(idx) << 3);
  endfunction

  if (PIPELINE_SLAVE_DATA_WIDTH >= TXN_W) begin : g_slv_wide
    assign slv_txn_s = mptw_transaction_t'(stage_slave_data[TXN_W-1:0]);
  end else begin : g_slv_narrow
    assign slv_txn_s = mptw_transaction_t'({{(TXN_W-PIPELINE_SLAVE_DATA_WIDTH){1'b0}}, stage_slave_data});
  end

  if (PIPELINE_MASTER_DATA_WIDTH >= TXN_W) begin : g_mst_wide
    assign stage_master_data = {{(PIPELINE_MASTER_DATA_WIDTH-TXN_W){1'b0}}, txn_q};
  end else begin : g_mst_narrow
    assign stage_master_data = txn_q[PIPELINE_MASTER_DATA_WIDTH-1:0];
  end

  assign entry_v_s     = walk_mem_rdata[0];
  assign entry_leaf_s  = walk_mem_rdata[1];
  assign entry_ppn_s   = walk_mem_rdata[53:10];
  assign next_level_s  = level_q - 2'd1;
  // A non-leaf entry at the last level has nowhere to point, so it is treated like an invalid one.
  assign entry_fault_s = walk_mem_error | ~entry_v_s | (~entry_leaf_s & (level_q == 2'd0));

  // Walk FSM; every handshake and memory output is a register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      slave_ready_q  <= 1'b0;
      master_valid_q <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= '0;
      level_q        <= 2'd0;
      txn_q          <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!slave_ready_q) begin
            slave_ready_q <= 1'b1;
          end else if (stage_slave_valid) begin
            slave_ready_q <= 1'b0;
            txn_q         <= slv_txn_s;
            if (slv_txn_s.walking == MPT_WALKING_DO) begin
              txn_q.walking <= MPT_WALKING_SKIP;
              level_q       <= TOP_LEVEL;
              mem_req_q     <= 1'b1;
              mem_addr_q    <= entry_addr_f(slv_txn_s.mmpt.ppn, TOP_LEVEL, slv_txn_s.spa);
              state_q       <= REQ;
            end else begin
              master_valid_q <= 1'b1;
              state_q        <= OUT;
            end
          end
        end
        REQ: begin
          if (walk_mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (walk_mem_valid) begin
            if (entry_fault_s) begin
              txn_q.rpa      <= '0;
              master_valid_q <= 1'b1;
              state_q        <= OUT;
            end else if (entry_leaf_s) begin
              txn_q.rpa      <= MPT_RPA_WIDTH'(walk_mem_rdata);
              master_valid_q <= 1'b1;
              state_q        <= OUT;
            end else begin
              level_q    <= next_level_s;
              mem_req_q  <= 1'b1;
              mem_addr_q <= entry_addr_f(entry_ppn_s, next_level_s, txn_q.spa);
              state_q    <= REQ;
            end
          end
        end
        OUT: begin
          if (stage_master_ready) begin
            master_valid_q <= 1'b0;
            slave_ready_q  <= 1'b1;
            state_q        <= IDLE;
          end
        end
        default: begin
          state_q        <= IDLE;
          slave_ready_q  <= 1'b0;
          master_valid_q <= 1'b0;
          mem_req_q      <= 1'b0;
        end
      endcase
    end
  end

  assign stage_slave_ready  = slave_ready_q;
  assign stage_master_valid = master_valid_q;
  assign walk_mem_req       = mem_req_q;
  assign walk_mem_addr      = mem_addr_q;
  assign walk_mem_wdata     = '0;
  assign walk_mem_we        = 1'b0;
  assign walk_mem_be        = {(MEMORY_DATA_WIDTH/8){1'b1}};

`ifdef MPT_WALK_PERF_COUNTERS_EN
  logic [31:0] walk_count_q;
  logic [31:0] fault_count_q;
  logic        walk_start_s;
  logic        fault_evt_s;

  assign walk_start_s = (state_q == IDLE) & slave_ready_q & stage_slave_valid
                      & (slv_txn_s.walking == MPT_WALKING_DO);
  assign fault_evt_s  = (state_q == WAIT) & walk_mem_valid & entry_fault_s;

  // Saturating walk and fault event counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      walk_count_q  <= 32'd0;
      fault_count_q <= 32'd0;
    end else begin
      if (walk_start_s && (walk_count_q != 32'hFFFF_FFFF)) begin
        walk_count_q <= walk_count_q + 32'd1;
      end
      if (fault_evt_s && (fault_count_q != 32'hFFFF_FFFF)) begin
        fault_count_q <= fault_count_q + 32'd1;
      end
    end
  end

  assign walk_count_o  = walk_count_q;
  assign fault_count_o = fault_count_q;
`endif

endmodule

// File: doc/mpt_walk_stage.md
Name: mpt_walk_stage

Overview:
- Pipeline stage directly downstream of the PLB lookup stage in the MPT walker.
- Consumes `mptw_transaction_t` transactions from `mpt_pkg`.
- Transactions marked `MPT_WALKING_SKIP` (PLB hit) pass through unchanged after one register stage.
- Transactions marked `MPT_WALKING_DO` trigger a multi-level MPT table walk over a MEM/SRAM master port. The fetched leaf entry is placed in `rpa` and the transaction is forwarded to the downstream permission-check stage.

Parameters:
- PIPELINE_SLAVE_DATA_WIDTH, 32, width of the slave data bus; carries `mptw_transaction_t`.
- PIPELINE_MASTER_DATA_WIDTH, 32, width of the master data bus.
- MEMORY_DATA_WIDTH, 64, MPT entry width.
- MEMORY_ADDR_WIDTH, 64, memory address width.
- WALK_LEVELS, 3, number of table levels; must be between 1 and 4.
- LEVEL_IDX_WIDTH, 9, SPA index bits consumed per level.
- PAGE_OFFSET_WIDTH, 12, SPA offset bits not used for indexing.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- stage_slave_valid  in  1  upstream transaction valid.
- stage_slave_ready  out  1  stage accepts a transaction.
- stage_slave_data  in  PIPELINE_SLAVE_DATA_WIDTH  incoming transaction.
- stage_master_valid  out  1  result valid.
- stage_master_ready  in  1  downstream accepts the result.
- stage_master_data  out  PIPELINE_MASTER_DATA_WIDTH  outgoing transaction.
- walk_mem_req  out  1  memory request.
- walk_mem_gnt  in  1  request granted.
- walk_mem_valid  in  1  read data valid.
- walk_mem_addr  out  MEMORY_ADDR_WIDTH  entry address.
- walk_mem_rdata  in  MEMORY_DATA_WIDTH  entry read data.
- walk_mem_wdata  out  MEMORY_DATA_WIDTH  tied to '0.
- walk_mem_we  out  1  tied to 0.
- walk_mem_be  out  MEMORY_DATA_WIDTH/8  tied to all ones.
- walk_mem_error  in  1  access error, sampled with walk_mem_valid.

Behaviour:
- Reset: asynchronous and active-low. Returns the FSM to IDLE, clears the held transaction and the level counter, and drives slave_ready=0, master_valid=0, mem_req=0, mem_addr=0. slave_ready rises in the first cycle after reset deassertion.
- FSM states: IDLE, REQ, WAIT, OUT.
- IDLE: slave_ready=1. On slave_valid&&slave_ready the transaction is latched.
  - walking==SKIP: go to OUT.
  - walking==DO: level=WALK_LEVELS-1, base=mmpt.ppn<<PAGE_OFFSET_WIDTH, go to REQ.
- REQ: mem_req=1 and mem_addr = base + (idx<<3), where idx = spa[PAGE_OFFSET_WIDTH+level*LEVEL_IDX_WIDTH +: LEVEL_IDX_WIDTH], zero-extended; the addition wraps modulo 2^MEMORY_ADDR_WIDTH. Address is held stable until gnt; on gnt go to WAIT.
- WAIT: mem_req=0; one outstanding request only. walk_mem_valid is sampled only in WAIT; valid asserted in the gnt cycle is not expected and is ignored.
- Entry decode: bit0=V, bit1=LEAF, bits[53:10]=next PPN.
- Entry evaluation on mem_valid:
  - error=1, or V=0, or (LEAF=0 && level==0): fault; rpa='0, go to OUT.
  - LEAF=1: rpa=rdata truncated/zero-extended to the rpa field; go to OUT.
  - Otherwise: base=next_ppn<<PAGE_OFFSET_WIDTH, level-=1, go to REQ.
- Output fields: walking=MPT_WALKING_SKIP for every walked transaction. mmpt, spa and access_type are copied unchanged. SKIP transactions are forwarded bit-identical.
- OUT: master_valid=1 with data held stable until master_ready. On handshake go to IDLE. No new slave transaction is accepted before the next cycle, so there is no same-cycle bubble-free pass-through.
- Latency from accept to master_valid:
  - SKIP: 1 cycle.
  - Walk: sum over levels of (cycles to gnt + 1 + memory latency), plus 1.
- Backpressure: master_ready low holds the stage in OUT indefinitely with slave_ready=0.
- Reset mid-walk: an in-flight memory response after reset is ignored, since WAIT is not entered.

Optional Feature:
- Macro: MPT_WALK_PERF_COUNTERS_EN.
- When defined:
  - Adds outputs walk_count_o [31:0], incremented on each DO transaction entering REQ from IDLE.
  - Adds fault_count_o [31:0], incremented on each fault.
  - Both saturate at 0xFFFFFFFF and are reset to 0.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- SKIP pass-through: SKIP transaction spa=0x1234 accepted at cycle N with master_ready=1 -> master_valid at N+1, data bit-identical, mem_req never asserted.
- 3-level walk to a leaf: mmpt.ppn=0x80, spa=0x0040_3000, zero-wait memory with 1-cycle latency, entries V=1 non-leaf ppn=0x81, V=1 non-leaf ppn=0x82, leaf 0x0000_0000_0000_2C03 -> addresses 0x80000, 0x81000+(idx1<<3), 0x82000+(3<<3); rpa=0x2C03, walking=SKIP.
- Invalid entry at level 1: level-1 entry V=0 -> exactly two memory requests, rpa=0, master_valid asserted.
- Memory error: walk_mem_error=1 on the first response -> fault after one request, rpa=0; fault_count_o=1 when MPT_WALK_PERF_COUNTERS_EN is defined.
- Grant stall and backpressure: gnt delayed 4 cycles -> mem_addr stable during the stall; master_ready low for 5 cycles -> data stable and slave_ready=0 throughout.
- Reset mid-walk: rst_ni asserted while in WAIT, late mem_valid arrives after release -> outputs at reset values, response ignored, next SKIP transaction completes normally.
